// File: rtl/ariane_pkg.sv
// Shared core types: the BHT update pulse and the entry buffered by the BHT update producer.
package ariane_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        taken;
    } bht_update_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
    } bhtu_entry_t;

endpackage

// File: rtl/bht_update_fifo.sv
// Small register-array FIFO with occupancy count; flush empties it on the next edge.
module bht_update_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = bhtu_entry_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  logic pop_i,
    input  T     data_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   cnt_q;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];

    // Guard against misuse so the count can never leave [0, DEPTH].
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (do_pop) rptr_q <= rptr_q + PtrW'(1);
            if (do_push && !do_pop) cnt_q <= cnt_q + (PtrW + 1)'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - (PtrW + 1)'(1);
        end
    end

endmodule

// File: rtl/bht_update_gen.sv
// Buffers resolved conditional branches and drains them as one BHT update pulse per cycle,
// with saturating counters for issued updates and accepted conditional mispredicts.
module bht_update_gen
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              debug_mode_i,
    input  logic              resolve_valid_i,
    output logic              resolve_ready_o,
    input  logic [63:0]       resolve_pc_i,
    input  logic              resolve_taken_i,
    input  logic              resolve_is_cond_i,
    input  logic              resolve_mispredict_i,
    output bht_update_t       bht_update_o,
    output logic [CNT_W-1:0]  upd_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    bhtu_entry_t      push_entry, head_entry;
    logic             full, empty, accept, push, upd_valid, mispred_inc;
    logic [CNT_W-1:0] upd_cnt_q, upd_cnt_d, mispred_cnt_q, mispred_cnt_d;

    // Ready deliberately ignores a same-cycle pop to keep the path short.
    assign resolve_ready_o = !full && !flush_i;
    assign accept          = resolve_valid_i && resolve_ready_o;
    assign push            = accept && resolve_is_cond_i;
    assign mispred_inc     = push && resolve_mispredict_i;
    assign upd_valid       = !empty && !debug_mode_i && !flush_i;

    assign push_entry.pc    = resolve_pc_i;
    assign push_entry.taken = resolve_taken_i;

    bht_update_fifo #(
        .DEPTH (DEPTH),
        .T     (bhtu_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (upd_valid),
        .data_i  (push_entry),
        .data_o  (head_entry),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        bht_update_o       = '0;
        bht_update_o.valid = upd_valid;
        if (!empty) begin
            bht_update_o.pc    = head_entry.pc;
            bht_update_o.taken = head_entry.taken;
        end
    end

    always_comb begin
        upd_cnt_d     = upd_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid && upd_cnt_q != '1) upd_cnt_d = upd_cnt_q + CNT_W'(1);
        if (mispred_inc && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            upd_cnt_q     <= upd_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign upd_cnt_o     = upd_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_bht_update_gen.sv
// Directed bench for bht_update_gen: queue-based reference model checked every cycle,
// plus literal expectations for the main scenarios.
module tb_bht_update_gen;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, debug, valid, taken, is_cond, mispred;
    logic [63:0] pc;
    logic        ready, ready_s;
    bht_update_t upd, upd_s;
    logic [31:0] upd_cnt, mis_cnt;
    logic [1:0]  upd_cnt_s, mis_cnt_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bht_update_gen #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .flush_i              (flush),
        .debug_mode_i         (debug),
        .resolve_valid_i      (valid),
        .resolve_ready_o      (ready),
        .resolve_pc_i         (pc),
        .resolve_taken_i      (taken),
        .resolve_is_cond_i    (is_cond),
        .resolve_mispredict_i (mispred),
        .bht_update_o         (upd),
        .upd_cnt_o            (upd_cnt),
        .mispred_cnt_o        (mis_cnt)
    );

    bht_update_gen #(.DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .flush_i              (flush),
        .debug_mode_i         (debug),
        .resolve_valid_i      (valid),
        .resolve_ready_o      (ready_s),
        .resolve_pc_i         (pc),
        .resolve_taken_i      (taken),
        .resolve_is_cond_i    (is_cond),
        .resolve_mispredict_i (mispred),
        .bht_update_o         (upd_s),
        .upd_cnt_o            (upd_cnt_s),
        .mispred_cnt_o        (mis_cnt_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint n, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Reference model: ordered list of pending updates plus raw event totals.
    bhtu_entry_t mq[$];
    longint      upd_n = 0, mis_n = 0;

    always @(negedge clk) begin
        logic        e_ready, e_valid, e_taken;
        logic [63:0] e_pc;
        if (!rst_n) begin
            mq.delete();
            upd_n = 0;
            mis_n = 0;
            chk("rst_ready", ready, 1);
            chk("rst_upd", upd, '0);
            chk("rst_cnt", upd_cnt, 0);
            chk("rst_mis", mis_cnt, 0);
        end else begin
            e_ready = (mq.size() < DEPTH) && !flush;
            e_valid = (mq.size() > 0) && !debug && !flush;
            e_pc    = (mq.size() > 0) ? mq[0].pc : 64'h0;
            e_taken = (mq.size() > 0) ? mq[0].taken : 1'b0;
            chk("m_ready", ready, e_ready);
            chk("m_valid", upd.valid, e_valid);
            chk("m_pc", upd.pc, e_pc);
            chk("m_taken", upd.taken, e_taken);
            chk("m_upd_cnt", upd_cnt, sat(upd_n, 32));
            chk("m_mis_cnt", mis_cnt, sat(mis_n, 32));
            chk("m_upd_cnt_s", upd_cnt_s, sat(upd_n, 2));
            chk("m_mis_cnt_s", mis_cnt_s, sat(mis_n, 2));
            chk("m_valid_s", upd_s.valid, e_valid);
            if (flush) begin
                mq.delete();
            end else begin
                if (e_valid) begin
                    void'(mq.pop_front());
                    upd_n++;
                end
                if (valid && e_ready && is_cond) begin
                    mq.push_back('{pc: pc, taken: taken});
                    if (mispred) mis_n++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic report(input logic [63:0] p, input logic t, input logic c, input logic m);
        valid   = 1'b1;
        pc      = p;
        taken   = t;
        is_cond = c;
        mispred = m;
        step();
        valid   = 1'b0;
        pc      = 64'hx;
        taken   = 1'bx;
        is_cond = 1'bx;
        mispred = 1'bx;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; debug = 1'b0; valid = 1'b0;
        pc = '0; taken = 1'b0; is_cond = 1'b0; mispred = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // 1. Basic one-cycle latency.
        report(64'h8000_0010, 1'b1, 1'b1, 1'b0);
        chk("t1_valid", upd.valid, 1);
        chk("t1_pc", upd.pc, 64'h8000_0010);
        chk("t1_taken", upd.taken, 1);
        step();
        chk("t1_cnt", upd_cnt, 1);
        chk("t1_idle", upd.valid, 0);

        // 2. Fill under debug, fifth report is held off, then drain in order.
        debug = 1'b1;
        for (int i = 0; i < 5; i++) begin
            report(64'h2000 + 64'(8 * i), i[0], 1'b1, 1'b0);
            if (i == 3) chk("t2_full_ready", ready, 0);
        end
        chk("t2_debug_hold", upd.valid, 0);
        debug = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain_valid", upd.valid, 1);
            chk("t2_drain_pc", upd.pc, 64'h2000 + 64'(8 * k));
            step();
        end
        chk("t2_empty", upd.valid, 0);
        chk("t2_cnt", upd_cnt, 5);

        // 3. Non-conditional reports are filtered and never counted.
        report(64'h3000, 1'b1, 1'b0, 1'b0);
        chk("t3_filtered", upd.valid, 0);
        report(64'h3004, 1'b0, 1'b1, 1'b1);
        chk("t3_pc", upd.pc, 64'h3004);
        step();
        chk("t3_mis", mis_cnt, 1);
        report(64'h3008, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("t3_mis_nc", mis_cnt, 1);
        chk("t3_cnt", upd_cnt, 6);

        // 4. Flush with a report presented: nothing accepted, queue emptied.
        debug = 1'b1;
        for (int i = 0; i < 3; i++) report(64'h4000 + 64'(4 * i), 1'b1, 1'b1, 1'b0);
        flush = 1'b1; valid = 1'b1; pc = 64'h4444; taken = 1'b1; is_cond = 1'b1; mispred = 1'b1;
        #1;
        chk("t4_ready", ready, 0);
        chk("t4_valid", upd.valid, 0);
        step();
        flush = 1'b0; valid = 1'b0; debug = 1'b0;
        #1;
        chk("t4_empty", upd.valid, 0);
        chk("t4_ready_after", ready, 1);
        step();
        chk("t4_cnt", upd_cnt, 6);
        chk("t4_mis", mis_cnt, 1);

        // 5. Back-to-back stream wraps the pointers several times.
        for (int k = 0; k < 10; k++) begin
            chk("t5_ready", ready, 1);
            report(64'h100 + 64'(4 * k), k[1], 1'b1, 1'b0);
            chk("t5_pc", upd.pc, 64'h100 + 64'(4 * k));
        end
        idle(2);
        chk("t5_cnt", upd_cnt, 16);

        // 6. Saturation on the narrow instance, then async reset mid-stream.
        @(posedge clk); #1; rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) report(64'h600 + 64'(4 * k), 1'b1, 1'b1, 1'b1);
        idle(2);
        chk("t6_sat", upd_cnt_s, 3);
        chk("t6_mis_sat", mis_cnt_s, 3);
        chk("t6_cnt", upd_cnt, 5);
        for (int k = 0; k < 3; k++) report(64'h700 + 64'(4 * k), 1'b1, 1'b1, 1'b1);
        valid = 1'b1; pc = 64'h7777; is_cond = 1'b1; taken = 1'b1; mispred = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", upd.valid, 0);
        chk("t6_rst_pc", upd.pc, 0);
        chk("t6_rst_cnt", upd_cnt, 0);
        chk("t6_rst_cnt_s", upd_cnt_s, 0);
        chk("t6_rst_mis", mis_cnt, 0);
        valid = 1'b0;
        step();
        rst_n = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
